// File: rtl/pbvi_pkg.sv
// Shared widths, types and constants for the PBVI policy-lookup stage.
package pbvi_pkg;

    localparam int PROB_W = 16;
    localparam int ACT_W  = 2;
    localparam int VAL_W  = 33;

    typedef logic signed [15:0] alpha_t;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} dec_state_e;

    // Reported when no vector carries a legal action; below any reachable dot product.
    localparam logic signed [VAL_W-1:0] VAL_MIN = {1'b1, {(VAL_W-1){1'b0}}};

endpackage

// File: rtl/pbvi_decision_if.sv
// Bundle between the belief updater (master) and the policy-lookup stage (slave).
interface pbvi_decision_if #(
    parameter int NUM_ALPHA = 8
);
    import pbvi_pkg::*;

    logic                    en_decision;
    logic [PROB_W-1:0]       belief [0:1];
    alpha_t                  alpha [0:NUM_ALPHA-1][0:1];
    logic [ACT_W-1:0]        alpha_action [0:NUM_ALPHA-1];
    logic [ACT_W-1:0]        action;
    logic                    en_belief;
    logic                    action_valid;
    logic signed [VAL_W-1:0] best_value;
    logic                    busy;
    logic                    overrun;

    modport master (
        output en_decision, belief, alpha, alpha_action,
        input  action, en_belief, action_valid, best_value, busy, overrun
    );

    modport slave (
        input  en_decision, belief, alpha, alpha_action,
        output action, en_belief, action_valid, best_value, busy, overrun
    );

endinterface

// File: rtl/pbvi_dot2.sv
// Two-term dot product of a signed Q8.8 alpha pair with an unsigned Q0.16 belief pair.
module pbvi_dot2
    import pbvi_pkg::*;
(
    input  alpha_t                  a0,
    input  alpha_t                  a1,
    input  logic [PROB_W-1:0]       b0,
    input  logic [PROB_W-1:0]       b1,
    output logic signed [VAL_W-1:0] v
);

    logic signed [VAL_W-1:0] p0;
    logic signed [VAL_W-1:0] p1;

    // Beliefs are zero-extended so the multiply stays signed without flipping their sign.
    assign p0 = $signed({{(VAL_W-16){a0[15]}}, a0}) * $signed({{(VAL_W-PROB_W){1'b0}}, b0});
    assign p1 = $signed({{(VAL_W-16){a1[15]}}, a1}) * $signed({{(VAL_W-PROB_W){1'b0}}, b1});
    assign v  = p0 + p1;

endmodule

// File: rtl/pbvi_decision.sv
// Serial PBVI alpha-vector scan: picks the action whose vector maximises belief.alpha
// and hands it back to the belief updater with a one-cycle enable.
module pbvi_decision
    import pbvi_pkg::*;
#(
    parameter int NUM_ALPHA   = 8,
    parameter int NUM_ACTIONS = 3
) (
    input logic             clk,
    input logic             rst_n,
    pbvi_decision_if.slave  bus
);

    localparam int IDX_W = (NUM_ALPHA > 1) ? $clog2(NUM_ALPHA) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ALPHA - 1);
    localparam logic [ACT_W:0]   ACT_LIMIT = (ACT_W+1)'(NUM_ACTIONS);

    dec_state_e              state;
    logic                    en_d;
    logic [IDX_W-1:0]        idx;
    logic                    found;
    logic signed [VAL_W-1:0] best_val;
    logic [ACT_W-1:0]        best_act;
    logic [PROB_W-1:0]       b0_q;
    logic [PROB_W-1:0]       b1_q;

    logic [ACT_W-1:0]        action_q;
    logic                    en_belief_q;
    logic                    valid_q;
    logic signed [VAL_W-1:0] best_value_q;
    logic                    busy_q;
    logic                    overrun_q;

    logic                    rise;
    logic [ACT_W-1:0]        cur_tag;
    logic                    tag_ok;
    logic signed [VAL_W-1:0] cur_val;

    assign rise    = bus.en_decision & ~en_d;
    assign cur_tag = bus.alpha_action[idx];
    assign tag_ok  = ({1'b0, cur_tag} < ACT_LIMIT);

    pbvi_dot2 u_dot2 (
        .a0 (bus.alpha[idx][0]),
        .a1 (bus.alpha[idx][1]),
        .b0 (b0_q),
        .b1 (b1_q),
        .v  (cur_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            en_d         <= 1'b0;
            idx          <= '0;
            found        <= 1'b0;
            best_val     <= '0;
            best_act     <= '0;
            b0_q         <= '0;
            b1_q         <= '0;
            action_q     <= '0;
            en_belief_q  <= 1'b0;
            valid_q      <= 1'b0;
            best_value_q <= '0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            en_d        <= bus.en_decision;
            valid_q     <= 1'b0;
            en_belief_q <= 1'b0;

            if (rise && state != IDLE) begin
                overrun_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        b0_q   <= bus.belief[0];
                        b1_q   <= bus.belief[1];
                        idx    <= '0;
                        found  <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    // Strictly-greater replacement keeps the lowest index on ties.
                    if (tag_ok && (!found || cur_val > best_val)) begin
                        best_val <= cur_val;
                        best_act <= cur_tag;
                        found    <= 1'b1;
                    end
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    action_q     <= found ? best_act : '0;
                    best_value_q <= found ? best_val : VAL_MIN;
                    valid_q      <= 1'b1;
                    en_belief_q  <= 1'b1;
                    busy_q       <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.action       = action_q;
    assign bus.en_belief    = en_belief_q;
    assign bus.action_valid = valid_q;
    assign bus.best_value   = best_value_q;
    assign bus.busy         = busy_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_pbvi_decision.sv
// Scoreboard bench for pbvi_decision: randomized and directed alpha tables checked
// against an arithmetic reference model.
module tb_pbvi_decision;

    localparam int NUM_ALPHA   = 8;
    localparam int NUM_ACTIONS = 3;

    typedef struct {
        logic [1:0]         act;
        logic signed [32:0] val;
        int                 due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    exp_t sb[$];

    logic signed [15:0] t_alpha [0:NUM_ALPHA-1][0:1];
    logic [1:0]         t_tag   [0:NUM_ALPHA-1];
    logic [15:0]        t_bel   [0:1];

    pbvi_decision_if #(.NUM_ALPHA(NUM_ALPHA)) bus ();

    pbvi_decision #(
        .NUM_ALPHA   (NUM_ALPHA),
        .NUM_ACTIONS (NUM_ACTIONS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Best value from the table by direct arithmetic; illegal tags never compete.
    function automatic exp_t model_decision();
        exp_t   r;
        longint best  = 0;
        longint v;
        bit     found = 0;
        r.act = 2'd0;
        for (int i = 0; i < NUM_ALPHA; i++) begin
            if (int'(t_tag[i]) < NUM_ACTIONS) begin
                v = longint'(t_alpha[i][0]) * longint'(t_bel[0])
                  + longint'(t_alpha[i][1]) * longint'(t_bel[1]);
                if (!found || v > best) begin
                    best  = v;
                    r.act = t_tag[i];
                    found = 1;
                end
            end
        end
        if (!found) begin
            best = -64'sd4294967296;
        end
        r.val = best[32:0];
        r.due = 0;
        return r;
    endfunction

    task automatic clear_table();
        for (int i = 0; i < NUM_ALPHA; i++) begin
            t_alpha[i][0] = 16'sh0000;
            t_alpha[i][1] = 16'sh0000;
            t_tag[i]      = 2'd3;
        end
    endtask

    task automatic drive_table();
        bus.belief[0] = t_bel[0];
        bus.belief[1] = t_bel[1];
        for (int i = 0; i < NUM_ALPHA; i++) begin
            bus.alpha[i][0]     = t_alpha[i][0];
            bus.alpha[i][1]     = t_alpha[i][1];
            bus.alpha_action[i] = t_tag[i];
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || bus.busy) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL timeout: pending %0d busy %0b required 0 0", sb.size(), bus.busy);
            sb.delete();
        end
    endtask

    task automatic apply_stimulus(input int hold, input bit reedge);
        exp_t e;
        @(negedge clk);
        drive_table();
        e     = model_decision();
        e.due = cyc + NUM_ALPHA + 2;
        sb.push_back(e);
        bus.en_decision = 1'b1;
        if (reedge) begin
            @(negedge clk);
            bus.en_decision = 1'b0;
            @(negedge clk);
            bus.en_decision = 1'b1;
            @(negedge clk);
            bus.en_decision = 1'b0;
        end else begin
            repeat (hold) @(negedge clk);
            bus.en_decision = 1'b0;
        end
        wait_idle();
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.action_valid || bus.en_belief) begin
            check_output("pulse_align", 64'(bus.en_belief), 64'(bus.action_valid));
        end
        if (bus.action_valid) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_pulse: got action_valid 1 expected 0");
            end else begin
                e = sb.pop_front();
                check_output("action", bus.action, e.act);
                check_output("best_value", bus.best_value, e.val);
                check_output("latency", cyc, e.due);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_action"}, bus.action, 0);
        check_output({tag, "_en_belief"}, bus.en_belief, 0);
        check_output({tag, "_action_valid"}, bus.action_valid, 0);
        check_output({tag, "_best_value"}, bus.best_value, 0);
        check_output({tag, "_busy"}, bus.busy, 0);
        check_output({tag, "_overrun"}, bus.overrun, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.en_decision = 1'b0;
        t_bel[0]        = 16'h0000;
        t_bel[1]        = 16'h0000;
        clear_table();
        drive_table();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic selection, then held-output check against hand-computed constants.
        clear_table();
        t_bel[0] = 16'hC000; t_bel[1] = 16'h4000;
        t_alpha[0][0] = 16'sh0100; t_alpha[0][1] = 16'sh0000; t_tag[0] = 2'd1;
        t_alpha[1][0] = 16'sh0000; t_alpha[1][1] = 16'sh0100; t_tag[1] = 2'd2;
        apply_stimulus(1, 1'b0);
        repeat (2) @(negedge clk);
        check_output("basic_held_action", bus.action, 1);
        check_output("basic_held_value", bus.best_value, 64'h0000_0000_00C0_0000);

        // Tie: lowest index wins.
        clear_table();
        t_bel[0] = 16'h3000; t_bel[1] = 16'h9000;
        t_alpha[0][0] = 16'sh0100; t_alpha[0][1] = 16'sh0080; t_tag[0] = 2'd2;
        t_alpha[1][0] = 16'sh0100; t_alpha[1][1] = 16'sh0080; t_tag[1] = 2'd0;
        apply_stimulus(1, 1'b0);
        check_output("tie_action", bus.action, 2);

        // Negative values.
        clear_table();
        t_bel[0] = 16'h8000; t_bel[1] = 16'h8000;
        t_alpha[0][0] = 16'shFE00; t_alpha[0][1] = 16'shFE00; t_tag[0] = 2'd0;
        t_alpha[1][0] = 16'shFF00; t_alpha[1][1] = 16'shFF00; t_tag[1] = 2'd1;
        apply_stimulus(1, 1'b0);
        check_output("neg_value", bus.best_value, -64'sh0100_0000);

        // All tags illegal.
        clear_table();
        t_bel[0] = 16'h1234; t_bel[1] = 16'hABCD;
        for (int i = 0; i < NUM_ALPHA; i++) begin
            t_alpha[i][0] = 16'sh0200;
            t_alpha[i][1] = 16'sh0300;
        end
        apply_stimulus(1, 1'b0);
        check_output("none_value", bus.best_value, -64'sd4294967296);

        // Illegal vector carrying the largest value is skipped.
        clear_table();
        t_bel[0] = 16'h8000; t_bel[1] = 16'h7FFF;
        t_alpha[0][0] = 16'sh7FFF; t_alpha[0][1] = 16'sh7FFF; t_tag[0] = 2'd3;
        t_alpha[3][0] = 16'sh0100; t_alpha[3][1] = 16'sh0040; t_tag[3] = 2'd2;
        t_alpha[5][0] = 16'sh0010; t_alpha[5][1] = 16'sh0020; t_tag[5] = 2'd1;
        apply_stimulus(1, 1'b0);
        check_output("skip_action", bus.action, 2);

        // Level held high: one decision, no overrun.
        apply_stimulus(2, 1'b0);
        repeat (3) @(negedge clk);
        check_output("hold_overrun", bus.overrun, 0);

        // Randomized tables.
        for (int n = 0; n < 20; n++) begin
            t_bel[0] = 16'($urandom);
            t_bel[1] = 16'($urandom);
            for (int i = 0; i < NUM_ALPHA; i++) begin
                t_alpha[i][0] = 16'($urandom);
                t_alpha[i][1] = 16'($urandom);
                t_tag[i]      = 2'($urandom_range(0, 3));
            end
            apply_stimulus(int'($urandom_range(1, 3)), 1'b0);
        end

        // Second rising edge during the scan.
        apply_stimulus(1, 1'b1);
        check_output("reedge_overrun", bus.overrun, 1);
        apply_stimulus(1, 1'b0);
        check_output("overrun_sticky", bus.overrun, 1);

        // Reset mid-scan at idx 3.
        clear_table();
        t_bel[0] = 16'hFFFF; t_bel[1] = 16'h0001;
        t_alpha[2][0] = 16'sh0400; t_alpha[2][1] = 16'sh0100; t_tag[2] = 2'd1;
        @(negedge clk);
        drive_table();
        bus.en_decision = 1'b1;
        @(negedge clk);
        bus.en_decision = 1'b0;
        repeat (3) @(negedge clk);
        check_output("midscan_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midscan");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (NUM_ALPHA + 4) @(negedge clk);
        apply_stimulus(1, 1'b0);
        check_output("post_reset_action", bus.action, 1);

        wait_idle();
        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pbvi_decision.md
# pbvi_decision

Policy-lookup stage of the POMDP controller. It sits downstream of the belief updater and closes the loop back to it. On each `en_decision` rising edge it captures the two-state belief and scans a table of PBVI alpha vectors serially, one vector per cycle. It then selects the action of the vector with the largest belief·alpha dot product and returns that action, together with a one-cycle enable, to the belief updater.

## Interface
- `NUM_ALPHA`, 8: number of alpha vectors, ≥1.
- `NUM_ACTIONS`, 3: legal actions are 0..NUM_ACTIONS-1, ≤4.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en_decision`  in  1  level from the belief updater; only a rising edge starts a decision.
- `belief[0:1]`  in  16 each  unsigned Q0.16 belief; sampled on the start edge only.
- `alpha[0:NUM_ALPHA-1][0:1]`  in  16 each  signed Q8.8 alpha values; must be static while busy.
- `alpha_action[0:NUM_ALPHA-1]`  in  2 each  action tag per vector.
- `action`  out  2  selected action, held until the next decision.
- `en_belief`  out  1  one-cycle pulse that starts the belief updater; coincident with `action_valid`.
- `action_valid`  out  1  one-cycle pulse; `action` and `best_value` are valid in this cycle.
- `best_value`  out  33  signed Q9.24 winning dot product, held.
- `busy`  out  1  high in SCAN and DONE.
- `overrun`  out  1  sticky; set when a start edge arrives while busy.

## Operation
- Start condition: `en_decision & ~en_d & state==IDLE`, where `en_d` is `en_decision` registered.
- FSM states:
  - IDLE: on start, capture `belief`, clear `idx` and the found flag, go to SCAN.
  - SCAN: evaluate vector `idx`, increment `idx`; at `idx==NUM_ALPHA-1` go to DONE.
  - DONE: register the result, pulse `action_valid` and `en_belief`, return to IDLE.
- Per-vector value: `v = alpha[idx][0]*b0 + alpha[idx][1]*b1`.
  - Each product is the 16-bit signed alpha times the zero-extended 16-bit belief, giving a 33-bit signed result.
  - The sum is 33-bit signed and cannot overflow.
- Selection:
  - Vectors with `alpha_action >= NUM_ACTIONS` are skipped.
  - The first valid vector initializes the best value.
  - A later vector replaces it only if strictly greater, so ties go to the lowest index.
- No valid vector in the table: `action=0`, `best_value = -2^32`, and `action_valid` still pulses.
- A start edge while busy is ignored and sets `overrun`.

## Timing
- Reset values: `action=0`, `en_belief=0`, `action_valid=0`, `best_value=0`, `busy=0`, `overrun=0`; state=IDLE, `en_d=0`.
- Start edge sampled at clock edge k: SCAN occupies edges k+1..k+NUM_ALPHA.
- `action_valid` and `en_belief` are high for exactly the cycle after edge k+NUM_ALPHA+1, i.e. the first cycle in which `action_valid` is visible is NUM_ALPHA+1 cycles after the capture edge.
- Throughput: one decision per NUM_ALPHA+2 cycles at most.
- Earliest next start: the edge following DONE, provided `en_decision` has dropped and risen again.
- Reset mid-scan: immediate return to IDLE with all outputs at reset values; no pulse is produced for the aborted scan.
- `en_decision` held high for any length produces exactly one decision.

## Structure
- `pbvi_pkg`:
  - `PROB_W=16`, `ACT_W=2`, `VAL_W=33`
  - `typedef logic signed [15:0] alpha_t`
  - `typedef enum {IDLE, SCAN, DONE} dec_state_e`
  - `VAL_MIN` constant
- Sub-module `pbvi_dot2`: purely combinational two-term signed×unsigned dot product (alpha pair, belief pair → 33-bit signed).
- The top contains the FSM, index counter, edge detector, best-value/action registers and the overrun flag.

## Test plan
- Basic selection:
  - Stimulus: NUM_ALPHA=2, belief {0xC000,0x4000}; alpha0 {0x0100,0x0000} tag 1; alpha1 {0x0000,0x0100} tag 2.
  - Response: `action=1`, `best_value=0x00C00000`; `action_valid` and `en_belief` pulse once, NUM_ALPHA+1 cycles after capture.
- Tie:
  - Stimulus: two identical vectors, tags 2 and 0.
  - Response: `action=2` (lowest index wins).
- Negative values:
  - Stimulus: belief {0x8000,0x8000}; alpha0 {0xFE00,0xFE00} tag 0; alpha1 {0xFF00,0xFF00} tag 1.
  - Response: `action=1`, `best_value=-0x01000000`.
- Handshake:
  - Stimulus: `en_decision` held high for 2 cycles.
  - Response: one decision only; `overrun` stays 0.
  - Stimulus: a second rising edge during SCAN.
  - Response: ignored; `overrun=1` until reset.
- Invalid tags:
  - Stimulus: all tags = 3 with NUM_ACTIONS=3.
  - Response: `action=0`, `best_value=-2^32`, `action_valid` pulses.
  - Stimulus: one invalid vector carrying the largest value.
  - Response: that vector is skipped.
- Reset mid-scan:
  - Stimulus: assert `rst_n=0` at SCAN idx 3.
  - Response: all outputs return to reset values with no pulse; a new start then produces a correct decision.
